// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use bubble, flush and stall hold
// Optional perf counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [1:0]         id_alu_op,
    input  logic               id_funct7,
    input  logic [2:0]         id_funct3,
    input  logic               id_alu_src,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic               id_branch,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [RADDR_W-1:0] id_rs1,
    input  logic [RADDR_W-1:0] id_rs2,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               flush,
    input  logic               ex_stall,
    output logic               ex_valid,
    output logic [1:0]         ex_alu_op,
    output logic               ex_funct7,
    output logic [2:0]         ex_funct3,
    output logic               ex_alu_src,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
    output logic               ex_branch,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_pc,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               hazard_stall
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   perf_bubble_cnt,
    output logic [CNT_W-1:0]   perf_flush_cnt
`endif
);

    logic w_load_use;
    logic w_bubble;

    // A load writing x0 produces nothing to wait for.
    assign w_load_use = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                        ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign hazard_stall = w_load_use | ex_stall;
    assign w_bubble     = flush | w_load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= 2'b00;
            ex_funct7     <= 1'b0;
            ex_funct3     <= 3'b000;
            ex_alu_src    <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
        end else if (!ex_stall) begin
            ex_funct7     <= id_funct7;
            ex_funct3     <= id_funct3;
            ex_alu_src    <= id_alu_src;
            ex_rs1_data   <= id_rs1_data;
            ex_rs2_data   <= id_rs2_data;
            ex_imm        <= id_imm;
            ex_pc         <= id_pc;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
            // Flush outranks load-use, but both leave the same bubble behind.
            if (w_bubble) begin
                ex_valid      <= 1'b0;
                ex_alu_op     <= 2'b00;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_branch     <= 1'b0;
            end else begin
                ex_valid      <= id_valid;
                ex_alu_op     <= id_alu_op;
                ex_mem_read   <= id_mem_read;
                ex_mem_write  <= id_mem_write;
                ex_reg_write  <= id_reg_write;
                ex_mem_to_reg <= id_mem_to_reg;
                ex_branch     <= id_branch;
            end
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else if (!ex_stall) begin
            if (flush && (perf_flush_cnt != {CNT_W{1'b1}}))
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            if (!flush && w_load_use && (perf_bubble_cnt != {CNT_W{1'b1}}))
                perf_bubble_cnt <= perf_bubble_cnt + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - table-driven scoreboard bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [1:0]  id_alu_op;
    logic        id_funct7;
    logic [2:0]  id_funct3;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        flush, ex_stall;
    logic        ex_valid;
    logic [1:0]  ex_alu_op;
    logic        ex_funct7;
    logic [2:0]  ex_funct3;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        hazard_stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [3:0]  perf_bubble_cnt, perf_flush_cnt;
`endif

    id_ex_pipe_reg #(
        .XLEN(32), .RADDR_W(5)
`ifdef ID_EX_PERF_CNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_op(id_alu_op),
        .id_funct7(id_funct7), .id_funct3(id_funct3), .id_alu_src(id_alu_src),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .ex_stall(ex_stall),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .hazard_stall(hazard_stall)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [1:0] op;
        logic       mr, mw, rw;
        logic [4:0] rs1, rs2, rd;
        logic       fl, st;
        logic       e_haz, e_valid;
        logic [1:0] e_op;
        logic       e_mr, e_mw, e_rw;
        logic [4:0] e_rd, e_rs1;
    } vec_t;

    typedef struct {
        int         idx;
        logic       e_valid;
        logic [1:0] e_op;
        logic       e_mr, e_mw, e_rw;
        logic [4:0] e_rd, e_rs1;
    } exp_t;

    vec_t tbl[21];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t v(logic valid, logic [1:0] op, logic mr, logic mw, logic rw,
                               logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                               logic fl, logic st, logic e_haz, logic e_valid, logic [1:0] e_op,
                               logic e_mr, logic e_mw, logic e_rw, logic [4:0] e_rd,
                               logic [4:0] e_rs1);
        vec_t r;
        r.valid = valid; r.op = op; r.mr = mr; r.mw = mw; r.rw = rw;
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.fl = fl; r.st = st;
        r.e_haz = e_haz; r.e_valid = e_valid; r.e_op = e_op; r.e_mr = e_mr;
        r.e_mw = e_mw; r.e_rw = e_rw; r.e_rd = e_rd; r.e_rs1 = e_rs1;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_id(logic valid, logic [1:0] op, logic mr, logic mw, logic rw,
                            logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                            logic fl, logic st, logic [31:0] tag);
        id_valid = valid; id_alu_op = op; id_mem_read = mr; id_mem_write = mw;
        id_reg_write = rw; id_mem_to_reg = mr; id_branch = 1'b0;
        id_funct7 = tag[0]; id_funct3 = tag[3:1]; id_alu_src = tag[4];
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = 32'h1000_0000 + tag; id_rs2_data = 32'h2000_0000 + tag;
        id_imm = 32'h3000_0000 + tag; id_pc = 32'h0000_4000 + (tag << 2);
        flush = fl; ex_stall = st;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Sequence rows: inputs | expected hazard_stall | expected EX state after the edge
        tbl[0]  = v(1, 2'b00, 1, 0, 1,  1, 0,  5, 0, 0,  0, 1, 2'b00, 1, 0, 1,  5,  1);
        tbl[1]  = v(1, 2'b10, 0, 0, 1,  5, 7,  6, 0, 0,  1, 0, 2'b00, 0, 0, 0,  6,  5);
        tbl[2]  = v(1, 2'b10, 0, 0, 1,  5, 7,  6, 0, 0,  0, 1, 2'b10, 0, 0, 1,  6,  5);
        tbl[3]  = v(1, 2'b00, 1, 0, 1,  2, 0,  0, 0, 0,  0, 1, 2'b00, 1, 0, 1,  0,  2);
        tbl[4]  = v(1, 2'b10, 0, 0, 1,  0, 0,  7, 0, 0,  0, 1, 2'b10, 0, 0, 1,  7,  0);
        tbl[5]  = v(1, 2'b00, 1, 0, 1,  3, 0,  9, 0, 0,  0, 1, 2'b00, 1, 0, 1,  9,  3);
        tbl[6]  = v(1, 2'b10, 0, 0, 1,  4, 4,  8, 0, 0,  0, 1, 2'b10, 0, 0, 1,  8,  4);
        tbl[7]  = v(1, 2'b00, 1, 0, 1,  3, 0,  9, 0, 0,  0, 1, 2'b00, 1, 0, 1,  9,  3);
        tbl[8]  = v(0, 2'b10, 0, 0, 1,  9, 0, 10, 0, 0,  0, 0, 2'b10, 0, 0, 1, 10,  9);
        tbl[9]  = v(1, 2'b00, 1, 0, 1,  1, 0,  5, 0, 0,  0, 1, 2'b00, 1, 0, 1,  5,  1);
        tbl[10] = v(1, 2'b10, 0, 0, 1,  5, 0,  6, 1, 0,  1, 0, 2'b00, 0, 0, 0,  6,  5);
        tbl[11] = v(1, 2'b11, 0, 1, 1,  2, 0, 11, 1, 0,  0, 0, 2'b00, 0, 0, 0, 11,  2);
        tbl[12] = v(1, 2'b10, 1, 0, 1, 12, 0, 12, 1, 1,  1, 0, 2'b00, 0, 0, 0, 11,  2);
        tbl[13] = v(1, 2'b01, 0, 1, 0, 13, 0, 13, 1, 1,  1, 0, 2'b00, 0, 0, 0, 11,  2);
        tbl[14] = v(1, 2'b10, 1, 0, 1, 14, 0, 14, 1, 1,  1, 0, 2'b00, 0, 0, 0, 11,  2);
        tbl[15] = v(1, 2'b10, 0, 0, 1, 15, 0, 15, 1, 0,  0, 0, 2'b00, 0, 0, 0, 15, 15);
        tbl[16] = v(1, 2'b10, 0, 0, 1, 16, 0, 16, 0, 0,  0, 1, 2'b10, 0, 0, 1, 16, 16);
        tbl[17] = v(1, 2'b00, 1, 0, 1, 17, 0, 20, 0, 0,  0, 1, 2'b00, 1, 0, 1, 20, 17);
        tbl[18] = v(1, 2'b10, 0, 0, 1, 20, 0, 21, 0, 1,  1, 1, 2'b00, 1, 0, 1, 20, 17);
        tbl[19] = v(1, 2'b10, 0, 0, 1, 20, 0, 21, 0, 0,  1, 0, 2'b00, 0, 0, 0, 21, 20);
        tbl[20] = v(1, 2'b10, 0, 0, 1, 20, 0, 21, 0, 0,  0, 1, 2'b10, 0, 0, 1, 21, 20);

        drive_id(1, 2'b11, 1, 1, 1, 3, 4, 5, 0, 0, 32'h1f);
        do_reset();

        // Asynchronous reset mid-cycle with non-zero content in EX
        @(negedge clk);
        @(posedge clk); #1;
        chk("pre_reset_valid", ex_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_alu_op", ex_alu_op, 0);
        chk("rst_reg_write", ex_reg_write, 0);
        chk("rst_rd", ex_rd, 0);
        chk("rst_rs1_data", ex_rs1_data, 0);
        chk("rst_imm", ex_imm, 0);
        chk("rst_pc", ex_pc, 0);
        chk("rst_funct7", ex_funct7, 0);
`ifdef ID_EX_PERF_CNT_EN
        chk("rst_perf_bubble", perf_bubble_cnt, 0);
        chk("rst_perf_flush", perf_flush_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive_id(1, 2'b10, 0, 0, 1, 1, 2, 3, 0, 0, 32'h1);
        id_funct3 = 3'b000;
        @(posedge clk); #1;
        chk("first_alu_op", ex_alu_op, 2'b10);
        chk("first_funct7", ex_funct7, 1);
        chk("first_funct3", ex_funct3, 0);
        chk("first_valid", ex_valid, 1);
        chk("first_rs1_data", ex_rs1_data, 32'h1000_0001);

        do_reset();
        for (int i = 0; i < 21; i++) begin
            exp_t e;
            drive_id(tbl[i].valid, tbl[i].op, tbl[i].mr, tbl[i].mw, tbl[i].rw,
                     tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].fl, tbl[i].st, i);
            #1;
            chk($sformatf("row%0d_hazard_stall", i), hazard_stall, tbl[i].e_haz);
            e.idx = i; e.e_valid = tbl[i].e_valid; e.e_op = tbl[i].e_op;
            e.e_mr = tbl[i].e_mr; e.e_mw = tbl[i].e_mw; e.e_rw = tbl[i].e_rw;
            e.e_rd = tbl[i].e_rd; e.e_rs1 = tbl[i].e_rs1;
            sb.push_back(e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("row%0d_valid", e.idx), ex_valid, e.e_valid);
                chk($sformatf("row%0d_alu_op", e.idx), ex_alu_op, e.e_op);
                chk($sformatf("row%0d_mem_read", e.idx), ex_mem_read, e.e_mr);
                chk($sformatf("row%0d_mem_write", e.idx), ex_mem_write, e.e_mw);
                chk($sformatf("row%0d_reg_write", e.idx), ex_reg_write, e.e_rw);
                chk($sformatf("row%0d_rd", e.idx), ex_rd, e.e_rd);
                chk($sformatf("row%0d_rs1", e.idx), ex_rs1, e.e_rs1);
            end
            @(negedge clk);
        end

`ifdef ID_EX_PERF_CNT_EN
        chk("perf_bubble_after_table", perf_bubble_cnt, 2);
        chk("perf_flush_after_table", perf_flush_cnt, 3);
        // 16 more load-use bubbles push the 4-bit counter past its ceiling
        for (int k = 0; k < 16; k++) begin
            drive_id(1, 2'b00, 1, 0, 1, 1, 0, 5, 0, 0, k);
            @(negedge clk);
            drive_id(1, 2'b10, 0, 0, 1, 5, 0, 6, 0, 0, k);
            @(negedge clk);
            @(negedge clk);
        end
        chk("perf_bubble_saturated", perf_bubble_cnt, 4'hf);
        chk("perf_flush_unchanged", perf_flush_cnt, 3);
`endif

        // Reset while stalled holding a valid load
        drive_id(1, 2'b00, 1, 0, 1, 1, 0, 5, 0, 0, 32'h7);
        @(negedge clk);
        drive_id(1, 2'b10, 0, 0, 1, 8, 0, 9, 1, 1, 32'h8);
        @(posedge clk); #1;
        chk("stall_hold_valid", ex_valid, 1);
        chk("stall_hold_rd", ex_rd, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("stall_rst_valid", ex_valid, 0);
        chk("stall_rst_mem_read", ex_mem_read, 0);
        chk("stall_rst_rd", ex_rd, 0);
        chk("stall_rst_hazard", hazard_stall, 1);
        @(negedge clk);
        ex_stall = 1'b0;
        flush = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_load_valid", ex_valid, 1);
        chk("post_rst_load_rd", ex_rd, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the five-stage RISC-V core.
- Captures decoded control (ALUOp, funct7 bit, funct3) plus operands from Decode, and presents them to Execute.
- Execute's ALU control unit consumes ex_alu_op/ex_funct7/ex_funct3 directly.
- Owns load-use hazard detection, bubble insertion, branch flush and downstream stall hold.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC.
- RADDR_W, 5, register index width.
- CNT_W, 32, perf counter width (used only with ID_EX_PERF_CNT_EN).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  Decode holds a real instruction.
- id_alu_op  in  2  ALUOp from main control.
- id_funct7  in  1  instr[30].
- id_funct3  in  3  instr[14:12].
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1 each  control bits.
- id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN each  operands.
- id_rs1, id_rs2, id_rd  in  RADDR_W each  register indices.
- flush  in  1  taken branch/jump resolved in EX; kill the instruction entering EX.
- ex_stall  in  1  EX/MEM cannot accept; hold contents.
- ex_valid  out  1  EX holds a real instruction.
- ex_alu_op, ex_funct7, ex_funct3, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  registered copies.
- ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_rs1, ex_rs2, ex_rd  out  registered copies.
- hazard_stall  out  1  freeze PC and IF/ID (combinational).

Behaviour:
- Reset (async, rst_n=0): every ex_* output = 0, ex_valid=0. Perf counters = 0.
- load_use (comb) = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- hazard_stall = load_use | ex_stall.
- Per rising edge, priority order:
  1. ex_stall=1: hold all outputs unchanged. flush is ignored, because the resolving branch is still in EX and EX reasserts flush once the stall clears.
  2. flush=1: insert a bubble.
  3. load_use=1: insert a bubble. IF/ID holds via hazard_stall, so the dependent instruction retries next cycle.
  4. Otherwise: load every ex_* from id_*, and ex_valid=id_valid.
- Bubble definition:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg and ex_branch = 0; ex_alu_op = 2'b00.
  - All other fields load from id_* (don't-care downstream).
- id_valid=0 with no higher-priority event: all fields load, including control. Downstream must qualify control with ex_valid.
- Latency: 1 cycle ID to EX. Load-use costs exactly 1 bubble; a second cycle is impossible because the bubble has ex_mem_read=0.
- rd=x0 never triggers load_use.
- Reset mid-stall or mid-bubble: outputs return to zero immediately. No residual state.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Enabled:
  - Adds outputs perf_bubble_cnt [CNT_W] (increments on each load-use bubble actually inserted) and perf_flush_cnt [CNT_W] (increments on each flush applied).
  - Both counters saturate at all-ones, reset to 0, and do not count when ex_stall=1.
- Disabled: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with non-zero inputs → all ex_* = 0 immediately, without waiting for a clock edge. Release rst_n, drive id_valid=1, id_alu_op=2'b10, funct3=3'b000, funct7=1 → next edge ex_alu_op=2'b10, ex_funct7=1, ex_valid=1.
- Load-use: EX holds lw x5 (ex_mem_read=1, ex_rd=5); ID add x6,x5,x7 → hazard_stall=1 the same cycle; next edge ex_valid=0, ex_reg_write=0. The following edge loads the add with ex_rs1=5, and hazard_stall=0.
- No false hazard: EX lw x0, or ID rs1=rs2≠ex_rd, or id_valid=0 → hazard_stall=0, normal load.
- Flush: flush=1 with valid ID addi → ex_valid=0, ex_mem_write=0, ex_alu_op=00. With flush=1 and load_use=1 together, exactly one bubble is inserted, and perf_flush_cnt increments while perf_bubble_cnt does not.
- Stall: ex_stall=1 for 3 cycles with changing id_* and flush=1 → outputs frozen, hazard_stall=1. On release, the next edge applies the flush or load as normal.
- Perf saturation (CNT_W=4, macro on): 17 load-use bubbles → perf_bubble_cnt=15.
